// File: rtl/alu_shift_sequencer.sv
// Splits a 0..31-bit SLL/SRL/SRA into greedy 8/2/1 ALU steps, one step per cycle.
// done follows the start-accept edge by N+1 cycles; a start seen while busy is dropped, not queued.
module alu_shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] alu_operand,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] acc;
  logic [4:0]        rem;
  logic [1:0]        op_q;
  logic [4:0]        step;
  logic [5:0]        step_idx;
  logic [5:0]        base_code;
  logic [5:0]        code;
  logic              bypass;

  // Zero-length or illegal-type requests complete without touching the ALU.
  assign bypass = (shamt == 5'd0) || (op == 2'b01);

  always_comb begin
    state_n   = state;
    step      = 5'd1;
    step_idx  = 6'd0;
    base_code = 6'h00;
    code      = 6'h00;

    if (rem >= 5'd8) begin
      step     = 5'd8;
      step_idx = 6'd2;
    end else if (rem >= 5'd2) begin
      step     = 5'd2;
      step_idx = 6'd1;
    end

    case (op_q)
      2'b00:   base_code = 6'h0A;
      2'b10:   base_code = 6'h0D;
      2'b11:   base_code = 6'h10;
      default: base_code = 6'h00;
    endcase

    case (state)
      IDLE: begin
        if (start) begin
          state_n = bypass ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (op_q != 2'b01) begin
          code = base_code + step_idx;
        end
        if (rem == step) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign alu_operand = acc;
  assign alu_ctrl    = CTRL_W'(code);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      op_q   <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= operand;
            rem  <= shamt;
            op_q <= op;
            if (bypass) begin
              result <= operand;
            end
          end
        end
        SHIFT: begin
          acc <= alu_result;
          rem <= rem - step;
          if (rem == step) begin
            result <= alu_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a behavioural 1/2/8-step shifting ALU beside it.
module tb_alu_shift_sequencer;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] operand;
  logic [31:0] alu_operand;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  logic [5:0]  seq [0:15];
  int          nseq;
  int          done_cyc;
  int          done_cnt;
  logic [31:0] res_at_done;

  alu_shift_sequencer #(.DATA_W(32), .CTRL_W(6)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .op          (op),
    .shamt       (shamt),
    .operand     (operand),
    .alu_operand (alu_operand),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    case (alu_ctrl)
      6'h0A:   alu_result = alu_operand << 1;
      6'h0B:   alu_result = alu_operand << 2;
      6'h0C:   alu_result = alu_operand << 8;
      6'h0D:   alu_result = alu_operand >> 1;
      6'h0E:   alu_result = alu_operand >> 2;
      6'h0F:   alu_result = alu_operand >> 8;
      6'h10:   alu_result = $unsigned($signed(alu_operand) >>> 1);
      6'h11:   alu_result = $unsigned($signed(alu_operand) >>> 2);
      6'h12:   alu_result = $unsigned($signed(alu_operand) >>> 8);
      default: alu_result = alu_operand;
    endcase
  end

  // Issues one request and observes 12 cycles after the accept edge.
  // restart_mask bit k re-raises start during observation cycle k; reset_cyc pulls resetn low in that cycle.
  task automatic run_op(input logic [1:0] t_op, input logic [4:0] t_sh, input logic [31:0] t_val,
                        input logic [15:0] restart_mask, input int reset_cyc);
    @(posedge clock); #1;
    start = 1'b1; op = t_op; shamt = t_sh; operand = t_val;
    @(posedge clock); #1;
    start = 1'b0;
    operand = 32'h0000_0001; shamt = 5'd1; op = 2'b00;
    nseq = 0; done_cyc = -1; done_cnt = 0; res_at_done = 32'hDEAD_BEEF;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (busy && !done && nseq < 16) begin
        seq[nseq] = alu_ctrl;
        nseq++;
      end
      if (done) begin
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res_at_done = result;
        end
        done_cnt++;
      end
      start  = restart_mask[cyc];
      resetn = (cyc != reset_cyc);
      @(posedge clock); #1;
    end
    start  = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; op = 2'b00; shamt = 5'd0; operand = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    total++; if (alu_ctrl !== 6'h00) begin bad++; $display("FAIL reset_ctrl got=%h want=00", alu_ctrl); end
    resetn = 1'b1;
  endtask

  task automatic test_sll_31;
    logic [5:0] want;
    run_op(2'b00, 5'd31, 32'h0000_0001, 16'h0000, -1);
    total++; if (nseq !== 7) begin bad++; $display("FAIL sll31_steps got=%0d want=7", nseq); end
    for (int i = 0; i < 7; i++) begin
      want = (i < 3) ? 6'h0C : ((i < 6) ? 6'h0B : 6'h0A);
      total++; if (seq[i] !== want) begin bad++; $display("FAIL sll31_ctrl[%0d] got=%h want=%h", i, seq[i], want); end
    end
    total++; if (done_cyc !== 8) begin bad++; $display("FAIL sll31_latency got=%0d want=8", done_cyc); end
    total++; if (res_at_done !== 32'h8000_0000) begin bad++; $display("FAIL sll31_result got=%h want=80000000", res_at_done); end
  endtask

  task automatic test_sra_9;
    run_op(2'b11, 5'd9, 32'h8000_0000, 16'h0000, -1);
    total++; if (nseq !== 2) begin bad++; $display("FAIL sra9_steps got=%0d want=2", nseq); end
    total++; if (seq[0] !== 6'h12) begin bad++; $display("FAIL sra9_ctrl0 got=%h want=12", seq[0]); end
    total++; if (seq[1] !== 6'h10) begin bad++; $display("FAIL sra9_ctrl1 got=%h want=10", seq[1]); end
    total++; if (done_cyc !== 3) begin bad++; $display("FAIL sra9_latency got=%0d want=3", done_cyc); end
    total++; if (res_at_done !== 32'hFFC0_0000) begin bad++; $display("FAIL sra9_result got=%h want=ffc00000", res_at_done); end
  endtask

  task automatic test_srl_zero;
    run_op(2'b10, 5'd0, 32'hFFFF_FFFF, 16'h0000, -1);
    total++; if (nseq !== 0) begin bad++; $display("FAIL srl0_steps got=%0d want=0", nseq); end
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL srl0_latency got=%0d want=1", done_cyc); end
    total++; if (res_at_done !== 32'hFFFF_FFFF) begin bad++; $display("FAIL srl0_result got=%h want=ffffffff", res_at_done); end
  endtask

  task automatic test_illegal_op;
    run_op(2'b01, 5'd5, 32'h0000_1234, 16'h0000, -1);
    total++; if (nseq !== 0) begin bad++; $display("FAIL illegal_steps got=%0d want=0", nseq); end
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL illegal_latency got=%0d want=1", done_cyc); end
    total++; if (res_at_done !== 32'h0000_1234) begin bad++; $display("FAIL illegal_result got=%h want=00001234", res_at_done); end
  endtask

  task automatic test_restart_ignored;
    // start raised in the first SHIFT cycle and again in the DONE cycle
    run_op(2'b10, 5'd10, 32'hFFFF_FFFF, 16'b0000_0000_0000_1010, -1);
    total++; if (nseq !== 2) begin bad++; $display("FAIL restart_steps got=%0d want=2", nseq); end
    total++; if (seq[0] !== 6'h0F) begin bad++; $display("FAIL restart_ctrl0 got=%h want=0f", seq[0]); end
    total++; if (seq[1] !== 6'h0E) begin bad++; $display("FAIL restart_ctrl1 got=%h want=0e", seq[1]); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 3) begin bad++; $display("FAIL restart_latency got=%0d want=3", done_cyc); end
    total++; if (result !== 32'h003F_FFFF) begin bad++; $display("FAIL restart_result got=%h want=003fffff", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_op;
    run_op(2'b00, 5'd16, 32'h0000_0001, 16'h0000, 2);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL midreset_done_count got=%0d want=0", done_cnt); end
    total++; if (nseq !== 2) begin bad++; $display("FAIL midreset_steps got=%0d want=2", nseq); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h want=00000000", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    run_op(2'b00, 5'd3, 32'h0000_0001, 16'h0000, -1);
    total++; if (nseq !== 2) begin bad++; $display("FAIL after_reset_steps got=%0d want=2", nseq); end
    total++; if (seq[0] !== 6'h0B) begin bad++; $display("FAIL after_reset_ctrl0 got=%h want=0b", seq[0]); end
    total++; if (seq[1] !== 6'h0A) begin bad++; $display("FAIL after_reset_ctrl1 got=%h want=0a", seq[1]); end
    total++; if (done_cyc !== 3) begin bad++; $display("FAIL after_reset_latency got=%0d want=3", done_cyc); end
    total++; if (res_at_done !== 32'h0000_0008) begin bad++; $display("FAIL after_reset_result got=%h want=00000008", res_at_done); end
  endtask

  task automatic test_back_to_back;
    run_op(2'b10, 5'd3, 32'h8000_0000, 16'h0000, -1);
    total++; if (seq[0] !== 6'h0E) begin bad++; $display("FAIL b2b_a_ctrl0 got=%h want=0e", seq[0]); end
    total++; if (seq[1] !== 6'h0D) begin bad++; $display("FAIL b2b_a_ctrl1 got=%h want=0d", seq[1]); end
    total++; if (res_at_done !== 32'h1000_0000) begin bad++; $display("FAIL b2b_a_result got=%h want=10000000", res_at_done); end
    run_op(2'b11, 5'd17, 32'hF000_0000, 16'h0000, -1);
    total++; if (nseq !== 3) begin bad++; $display("FAIL b2b_b_steps got=%0d want=3", nseq); end
    total++; if (seq[2] !== 6'h10) begin bad++; $display("FAIL b2b_b_ctrl2 got=%h want=10", seq[2]); end
    total++; if (done_cyc !== 4) begin bad++; $display("FAIL b2b_b_latency got=%0d want=4", done_cyc); end
    total++; if (res_at_done !== 32'hFFFF_F800) begin bad++; $display("FAIL b2b_b_result got=%h want=fffff800", res_at_done); end
  endtask

  initial begin
    test_reset();
    test_sll_31();
    test_sra_9();
    test_srl_zero();
    test_illegal_op();
    test_restart_ignored();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
